secuenciador_horno: RTL and testbench
=====================================

# secuenciador_horno

Sequential oven controller. It extends the combinational interlock equations with a timed cook cycle, pause/resume on door opening, a latched emergency stop and a timed end-of-cycle alarm. It drives the heater, door-lock and alarm outputs directly and sits between the front-panel inputs and the oven power stage.

## Interface

Parameters:
- CLK_PER_SEC, default 1000: clock cycles per one-second tick (≥2).
- TIME_W, default 8: width of the cook-time value in seconds.
- ALARM_SECS, default 3: duration of the end-of-cycle alarm in seconds (≥1).

Ports:
- clk  in  1  — single system clock, rising edge.
- rst  in  1  — synchronous, active-high reset.
- S  in  1  — door sensor; 1 = door open.
- B  in  1  — emergency button; 1 = pressed.
- start  in  1  — start/resume request, sampled each cycle (level, acted on only in the states listed below).
- time_in  in  TIME_W  — cook time in seconds, sampled when a cycle starts from IDLE.
- H  out  1  — heater enable.
- P  out  1  — door release; 1 = released, 0 = locked.
- A  out  1  — alarm.
- remaining  out  TIME_W  — seconds left in the current cook cycle.
- busy  out  1  — 1 in COOK or PAUSE.

## Operation

- Five states: IDLE, COOK, PAUSE, DONE, EMERG.
- Moore outputs, decoded from the registered state:
  - IDLE: H=0, P=1, A=0.
  - COOK: H=1, P=0, A=0.
  - PAUSE: H=0, P=1, A=0.
  - DONE: H=0, P=1, A=1.
  - EMERG: H=0, P=1, A=1.
- Transition priority, highest first: rst > B > S > tick/start.
- From any state, B=1 → EMERG. On this transition remaining is cleared to 0 and the tick counter is cleared.
- IDLE → COOK when start=1, S=0, B=0 and time_in≠0.
  - remaining ← time_in; tick counter ← 0.
  - Otherwise the block stays in IDLE. A start with time_in=0 or with S=1 is ignored.
- COOK:
  - The tick counter runs from 0 to CLK_PER_SEC-1 and wraps.
  - Each wrap decrements remaining by 1.
  - A wrap while remaining=1 sets remaining to 0 and moves to DONE.
  - S=1 moves to PAUSE; remaining and the tick counter are held.
- PAUSE:
  - Counters are frozen.
  - start=1 with S=0 → COOK; counting resumes from the held tick value.
  - start while S=1 is ignored.
- DONE:
  - The alarm timer counts ALARM_SECS×CLK_PER_SEC cycles, then the block returns to IDLE.
  - S=1 during DONE goes to IDLE immediately (alarm acknowledged).
  - start is ignored.
- EMERG:
  - The state is held while B=1.
  - After B=0, the block leaves only when S=1 (operator opens the door), going to IDLE.
  - With B=0 and S=0 it stays in EMERG.
- The tick counter has width $clog2(CLK_PER_SEC). remaining never underflows below 0.
- Reset value, all outputs: state IDLE, H=0, P=1, A=0, remaining=0, busy=0. All counters are 0.
- Reset mid-operation behaves identically: the next cycle is IDLE with the values above.

## Timing

- Inputs are sampled at rising edge N; state and outputs change at N+1. Every response therefore has exactly 1 cycle of latency.
- Uninterrupted cook: H is high for exactly time_in×CLK_PER_SEC consecutive cycles.
- Alarm: A is high for exactly ALARM_SECS×CLK_PER_SEC cycles unless the door is opened.
- Pause: H is low from the cycle after S rises. Total H-high cycles across pauses still equals time_in×CLK_PER_SEC.
- Simultaneous B and S: B wins.
- Simultaneous S and a tick wrap in COOK: go to PAUSE, and the decrement for that wrap is applied.
- Simultaneous S and the final wrap in COOK: go to DONE, not PAUSE.
- Inputs are assumed synchronous to clk. Debounce and synchronisation happen upstream.

## Test plan

All scenarios use CLK_PER_SEC=4, TIME_W=8, ALARM_SECS=2.

1. Normal cycle.
   - Stimulus: rst, then start=1 for one cycle with time_in=3, S=0.
   - Response: H=1, P=0 for 12 cycles; remaining steps 3→2→1→0 every 4 cycles; then A=1, P=1 for 8 cycles; then IDLE with A=0.
2. Pause/resume.
   - Stimulus: S=1 six cycles into cook; later S=0 and start pulse.
   - Response: H=0 from the next cycle; remaining held at 2; busy stays 1; after resume, total H-high count is 12.
3. Emergency.
   - Stimulus: B=1 mid-cook; then B=0 with S=0 for 10 cycles; then S=1.
   - Response: next cycle after B=1 shows H=0, P=1, A=1, remaining=0; the block stays in EMERG while S=0; it reaches IDLE with A=0 one cycle after S=1.
4. Rejected starts.
   - Stimulus: start with time_in=0; start with S=1; start with B=1.
   - Response: H stays 0 and busy stays 0 in every case; the B case enters EMERG.
5. Alarm acknowledge.
   - Stimulus: S=1 in the 3rd cycle of DONE.
   - Response: A=0 on the next cycle; state IDLE.
6. Reset mid-cook.
   - Stimulus: rst=1 for one cycle at remaining=2.
   - Response: next cycle shows H=0, P=1, A=0, remaining=0, busy=0.

Source files
------------

// File: rtl/secuenciador_horno.sv
// Oven sequencer: timed cook cycle with door pause, latched
// emergency stop and timed end-of-cycle alarm.
module secuenciador_horno #(
   parameter int CLK_PER_SEC = 1000,
   parameter int TIME_W      = 8,
   parameter int ALARM_SECS  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              S,
   input  logic              B,
   input  logic              start,
   input  logic [TIME_W-1:0] time_in,
   output logic              H,
   output logic              P,
   output logic              A,
   output logic [TIME_W-1:0] remaining,
   output logic              busy
);

   localparam int TICK_W    = $clog2(CLK_PER_SEC);
   localparam int ALARM_LEN = ALARM_SECS * CLK_PER_SEC;
   localparam int ALARM_W   = $clog2(ALARM_LEN);

   localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(CLK_PER_SEC - 1);
   localparam logic [ALARM_W-1:0] ALARM_LAST = ALARM_W'(ALARM_LEN - 1);

   typedef enum logic [2:0] {
      IDLE,
      COOK,
      PAUSE,
      DONE,
      EMERG
   } state_t;

   state_t              state, state_n;
   logic [TIME_W-1:0]   rem_q, rem_n;
   logic [TICK_W-1:0]   tick_q, tick_n;
   logic [ALARM_W-1:0]  alarm_q, alarm_n;
   logic                wrap;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         rem_q   <= '0;
         tick_q  <= '0;
         alarm_q <= '0;
      end else begin
         state   <= state_n;
         rem_q   <= rem_n;
         tick_q  <= tick_n;
         alarm_q <= alarm_n;
      end
   end

   assign wrap = (tick_q == TICK_LAST);

   always_comb begin
      state_n = state;
      rem_n   = rem_q;
      tick_n  = tick_q;
      alarm_n = alarm_q;
      if (B) begin
         state_n = EMERG;
         rem_n   = '0;
         tick_n  = '0;
         alarm_n = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start && !S && time_in != '0) begin
                  state_n = COOK;
                  rem_n   = time_in;
                  tick_n  = '0;
               end
            end
            COOK: begin
               // The cycle that samples S is still a heating cycle,
               // so it is counted before the block pauses.
               if (wrap) begin
                  tick_n = '0;
                  if (rem_q != '0)
                     rem_n = rem_q - TIME_W'(1);
               end else begin
                  tick_n = tick_q + TICK_W'(1);
               end
               if (wrap && rem_q <= TIME_W'(1)) begin
                  state_n = DONE;
                  alarm_n = '0;
               end else if (S) begin
                  state_n = PAUSE;
               end
            end
            PAUSE: begin
               if (start && !S)
                  state_n = COOK;
            end
            DONE: begin
               if (S || alarm_q == ALARM_LAST) begin
                  state_n = IDLE;
                  alarm_n = '0;
               end else begin
                  alarm_n = alarm_q + ALARM_W'(1);
               end
            end
            EMERG: begin
               if (S)
                  state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_comb begin
      H    = 1'b0;
      P    = 1'b1;
      A    = 1'b0;
      busy = 1'b0;
      unique case (state)
         IDLE: ;
         COOK: begin
            H    = 1'b1;
            P    = 1'b0;
            busy = 1'b1;
         end
         PAUSE: busy = 1'b1;
         DONE:  A = 1'b1;
         EMERG: A = 1'b1;
         default: ;
      endcase
   end

   assign remaining = rem_q;

endmodule

// File: tb/tb_secuenciador_horno.sv
// Directed bench for secuenciador_horno with CLK_PER_SEC=4,
// TIME_W=8, ALARM_SECS=2.
module tb_secuenciador_horno;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       S = 1'b0;
   logic       B = 1'b0;
   logic       start = 1'b0;
   logic [7:0] time_in = 8'd0;
   logic       H, P, A, busy;
   logic [7:0] remaining;

   int total = 0;
   int passed = 0;
   int fails = 0;
   int hc;
   int guard;

   secuenciador_horno #(
      .CLK_PER_SEC(4),
      .TIME_W(8),
      .ALARM_SECS(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .S(S),
      .B(B),
      .start(start),
      .time_in(time_in),
      .H(H),
      .P(P),
      .A(A),
      .remaining(remaining),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_H"}, H, 0);
      chk({tag, "_P"}, P, 1);
      chk({tag, "_A"}, A, 0);
      chk({tag, "_rem"}, remaining, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   task automatic go(input logic [7:0] t);
      time_in = t;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      // reset
      step();
      chk_idle("reset");
      rst = 1'b0;
      step();
      chk_idle("post_reset");

      // 1: normal cycle
      go(8'd3);
      for (int k = 1; k <= 12; k++) begin
         chk("t1_H", H, 1);
         chk("t1_P", P, 0);
         chk("t1_rem", remaining, 3 - (k - 1) / 4);
         step();
      end
      for (int k = 1; k <= 8; k++) begin
         chk("t1_alarm_A", A, 1);
         chk("t1_alarm_P", P, 1);
         chk("t1_alarm_H", H, 0);
         chk("t1_alarm_rem", remaining, 0);
         step();
      end
      chk_idle("t1_end");

      // 2: pause and resume, then 5: alarm acknowledge
      go(8'd3);
      for (int k = 1; k < 6; k++) step();
      chk("t2_rem_k6", remaining, 2);
      S = 1'b1;
      step();
      chk("t2_pause_H", H, 0);
      chk("t2_pause_P", P, 1);
      chk("t2_pause_rem", remaining, 2);
      chk("t2_pause_busy", busy, 1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t2_start_door_open_H", H, 0);
      chk("t2_start_door_open_busy", busy, 1);
      step();
      chk("t2_hold_rem", remaining, 2);
      S = 1'b0;
      step();
      chk("t2_closed_no_start_H", H, 0);
      go(8'd0);
      chk("t2_resume_H", H, 1);
      hc = 6;
      guard = 0;
      while (H === 1'b1 && guard < 50) begin
         hc++;
         guard++;
         step();
      end
      chk("t2_total_H", hc, 12);
      chk("t5_done_A", A, 1);
      step();
      step();
      chk("t5_done3_A", A, 1);
      S = 1'b1;
      step();
      S = 1'b0;
      chk_idle("t5_ack");
      step();

      // 3: emergency
      go(8'd3);
      step();
      step();
      B = 1'b1;
      step();
      chk("t3_em_H", H, 0);
      chk("t3_em_P", P, 1);
      chk("t3_em_A", A, 1);
      chk("t3_em_rem", remaining, 0);
      chk("t3_em_busy", busy, 0);
      S = 1'b1;
      step();
      chk("t3_b_over_s_A", A, 1);
      S = 1'b0;
      B = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("t3_latched_A", A, 1);
      end
      S = 1'b1;
      step();
      S = 1'b0;
      chk_idle("t3_release");

      // 4: rejected starts
      go(8'd0);
      chk("t4_zero_H", H, 0);
      chk("t4_zero_busy", busy, 0);
      S = 1'b1;
      go(8'd5);
      S = 1'b0;
      chk("t4_door_H", H, 0);
      chk("t4_door_busy", busy, 0);
      B = 1'b1;
      go(8'd5);
      B = 1'b0;
      chk("t4_btn_H", H, 0);
      chk("t4_btn_busy", busy, 0);
      chk("t4_btn_A", A, 1);
      S = 1'b1;
      step();
      S = 1'b0;
      chk_idle("t4_clear");

      // 6: reset mid-cook
      go(8'd3);
      for (int k = 1; k < 5; k++) step();
      chk("t6_rem", remaining, 2);
      chk("t6_H", H, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_idle("t6_reset");
      step();
      chk_idle("t6_after");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
